play_ctrl: RTL and testbench

Transport controller for the music box. Sits directly downstream of the per-button debounce stages and consumes their one-cycle press pulses (play/pause, stop, next, prev). Keeps the player state and current track index. Drives the note sequencer with `track`, `playing`, and a one-cycle `restart` strobe, and takes back the sequencer's `track_done` to auto-advance.

---
 rtl/musicbox_pkg.sv | 13 +
 rtl/rise_det.sv | 25 ++
 rtl/play_ctrl.sv | 130 +++++++++++++
 tb/tb_play_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/musicbox_pkg.sv
// Shared types and constants for the music box: transport state encoding and
// the default track count used by the sequencer, track ROM and play_ctrl.
package musicbox_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } play_state_t;

  localparam int NUM_TRACKS_DEFAULT = 4;

endpackage

// File: rtl/rise_det.sv
// One-bit rising-edge detector. The history register follows the live input even
// during reset, so a level held across reset release is not seen as a new edge.
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = din;
  end

  always_ff @(posedge clk) begin
    prev_q <= prev_d;
  end

  always_comb begin
    rise = din & ~prev_q & ~rst;
  end

endmodule

// File: rtl/play_ctrl.sv
// Transport controller: turns debounced button pulses and the sequencer's
// end-of-track flag into player state, current track and a restart strobe.
module play_ctrl
  import musicbox_pkg::*;
#(
  parameter int NUM_TRACKS = NUM_TRACKS_DEFAULT,
  parameter int TRACK_W    = $clog2(NUM_TRACKS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               play_p,
  input  logic               stop_p,
  input  logic               next_p,
  input  logic               prev_p,
  input  logic               track_done,
  input  logic               loop_all,
  output logic [TRACK_W-1:0] track,
  output logic               playing,
  output logic               paused,
  output logic               restart
);

  localparam logic [TRACK_W:0]   NUM_TRACKS_X = (TRACK_W+1)'(NUM_TRACKS);
  localparam logic [TRACK_W-1:0] LAST_TRACK   = TRACK_W'(NUM_TRACKS - 1);

  logic play_e, stop_e, next_e, prev_e, done_e;

  rise_det u_play (.clk(clk), .rst(rst), .din(play_p),     .rise(play_e));
  rise_det u_stop (.clk(clk), .rst(rst), .din(stop_p),     .rise(stop_e));
  rise_det u_next (.clk(clk), .rst(rst), .din(next_p),     .rise(next_e));
  rise_det u_prev (.clk(clk), .rst(rst), .din(prev_p),     .rise(prev_e));
  rise_det u_done (.clk(clk), .rst(rst), .din(track_done), .rise(done_e));

  play_state_t        state_q, state_d;
  logic [TRACK_W-1:0] track_q, track_d;
  logic               restart_q, restart_d;

  logic [TRACK_W:0]   track_inc;
  logic [TRACK_W-1:0] track_nxt;
  logic [TRACK_W-1:0] track_prv;

  // Wrap arithmetic is done one bit wider so non-power-of-two counts wrap correctly.
  always_comb begin
    track_inc = {1'b0, track_q} + {{TRACK_W{1'b0}}, 1'b1};
    track_nxt = (track_inc >= NUM_TRACKS_X) ? '0 : track_inc[TRACK_W-1:0];
    track_prv = (track_q == '0) ? LAST_TRACK : (track_q - TRACK_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= STOP;
      track_q   <= '0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      track_q   <= track_d;
      restart_q <= restart_d;
    end
  end

  // Events are checked in priority order; the first match consumes the cycle.
  always_comb begin
    state_d   = state_q;
    track_d   = track_q;
    restart_d = 1'b0;
    unique case (state_q)
      STOP: begin
        if (stop_e) begin
          state_d = STOP;
        end else if (play_e) begin
          state_d   = PLAY;
          restart_d = 1'b1;
        end else if (next_e) begin
          track_d = track_nxt;
        end else if (prev_e) begin
          track_d = track_prv;
        end
      end
      PLAY: begin
        if (stop_e) begin
          state_d   = STOP;
          restart_d = 1'b1;
        end else if (play_e) begin
          state_d = PAUSE;
        end else if (next_e) begin
          track_d   = track_nxt;
          restart_d = 1'b1;
        end else if (prev_e) begin
          track_d   = track_prv;
          restart_d = 1'b1;
        end else if (done_e) begin
          restart_d = 1'b1;
          if (track_q != LAST_TRACK) begin
            track_d = track_nxt;
          end else if (loop_all) begin
            track_d = '0;
          end else begin
            track_d = '0;
            state_d = STOP;
          end
        end
      end
      PAUSE: begin
        if (stop_e) begin
          state_d   = STOP;
          restart_d = 1'b1;
        end else if (play_e) begin
          state_d = PLAY;
        end else if (next_e) begin
          track_d   = track_nxt;
          restart_d = 1'b1;
        end else if (prev_e) begin
          track_d   = track_prv;
          restart_d = 1'b1;
        end
      end
      default: begin
        state_d = STOP;
      end
    endcase
  end

  always_comb begin
    track   = track_q;
    playing = (state_q == PLAY);
    paused  = (state_q == PAUSE);
    restart = restart_q;
  end

endmodule

// File: tb/tb_play_ctrl.sv
// Directed bench for play_ctrl: each driven cycle queues the outputs expected
// after the following clock edge, and a monitor compares them independently.
module tb_play_ctrl;

  localparam int NT = 4;
  localparam int TW = 2;

  localparam logic [6:0] I_NONE = 7'h00;
  localparam logic [6:0] I_PLAY = 7'h01;
  localparam logic [6:0] I_STOP = 7'h02;
  localparam logic [6:0] I_NEXT = 7'h04;
  localparam logic [6:0] I_PREV = 7'h08;
  localparam logic [6:0] I_DONE = 7'h10;
  localparam logic [6:0] I_LOOP = 7'h20;
  localparam logic [6:0] I_RST  = 7'h40;

  logic          clk;
  logic          rst;
  logic          play_p, stop_p, next_p, prev_p, track_done, loop_all;
  logic [TW-1:0] track;
  logic          playing, paused, restart;

  typedef struct packed {
    logic [TW-1:0] trk;
    logic          ply;
    logic          psd;
    logic          rs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  play_ctrl #(.NUM_TRACKS(NT)) dut (
    .clk(clk), .rst(rst),
    .play_p(play_p), .stop_p(stop_p), .next_p(next_p), .prev_p(prev_p),
    .track_done(track_done), .loop_all(loop_all),
    .track(track), .playing(playing), .paused(paused), .restart(restart)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = '{trk: track, ply: playing, psd: paused, rs: restart};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs at %0t: got track=%0d playing=%0b paused=%0b restart=%0b, want track=%0d playing=%0b paused=%0b restart=%0b",
                 $time, a.trk, a.ply, a.psd, a.rs, e.trk, e.ply, e.psd, e.rs);
      end
    end
  end

  task automatic cyc(input logic [6:0] in, input int trk, input logic ply,
                     input logic psd, input logic rs);
    exp_t e;
    @(negedge clk);
    play_p     = in[0];
    stop_p     = in[1];
    next_p     = in[2];
    prev_p     = in[3];
    track_done = in[4];
    loop_all   = in[5];
    rst        = in[6];
    e = '{trk: TW'(trk), ply: ply, psd: psd, rs: rs};
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    {play_p, stop_p, next_p, prev_p, track_done, loop_all} = '0;

    // reset and first play
    cyc(I_RST,  0, 0, 0, 0);
    cyc(I_RST,  0, 0, 0, 0);
    cyc(I_NONE, 0, 0, 0, 0);
    cyc(I_PLAY, 0, 1, 0, 1);
    cyc(I_NONE, 0, 1, 0, 0);
    // pause / resume
    cyc(I_PLAY, 0, 0, 1, 0);
    cyc(I_NONE, 0, 0, 1, 0);
    cyc(I_PLAY, 0, 1, 0, 0);
    cyc(I_NONE, 0, 1, 0, 0);
    // walk to track 3, wrap next, immediate prev
    cyc(I_NEXT, 1, 1, 0, 1);
    cyc(I_NONE, 1, 1, 0, 0);
    cyc(I_NEXT, 2, 1, 0, 1);
    cyc(I_NONE, 2, 1, 0, 0);
    cyc(I_NEXT, 3, 1, 0, 1);
    cyc(I_NONE, 3, 1, 0, 0);
    cyc(I_NEXT, 0, 1, 0, 1);
    cyc(I_PREV, 3, 1, 0, 1);
    cyc(I_NONE, 3, 1, 0, 0);
    // auto-advance at last track, loop on then off
    cyc(I_DONE | I_LOOP, 0, 1, 0, 1);
    cyc(I_LOOP,          0, 1, 0, 0);
    cyc(I_PREV,          3, 1, 0, 1);
    cyc(I_NONE,          3, 1, 0, 0);
    cyc(I_DONE,          0, 0, 0, 1);
    cyc(I_NONE,          0, 0, 0, 0);
    // track changes in STOP carry no restart; done ignored
    cyc(I_NEXT, 1, 0, 0, 0);
    cyc(I_NONE, 1, 0, 0, 0);
    cyc(I_PREV, 0, 0, 0, 0);
    cyc(I_NONE, 0, 0, 0, 0);
    cyc(I_PREV, 3, 0, 0, 0);
    cyc(I_NONE, 3, 0, 0, 0);
    cyc(I_DONE, 3, 0, 0, 0);
    cyc(I_NONE, 3, 0, 0, 0);
    // simultaneous stop+play+next during PLAY
    cyc(I_PLAY, 3, 1, 0, 1);
    cyc(I_NONE, 3, 1, 0, 0);
    cyc(I_STOP | I_PLAY | I_NEXT, 3, 0, 0, 1);
    cyc(I_NONE, 3, 0, 0, 0);
    // play held for 10 cycles from STOP
    cyc(I_PLAY, 3, 1, 0, 1);
    for (int i = 0; i < 9; i++) cyc(I_PLAY, 3, 1, 0, 0);
    cyc(I_NONE, 3, 1, 0, 0);
    // into PAUSE, track changes while paused, done ignored
    cyc(I_PREV, 2, 1, 0, 1);
    cyc(I_NONE, 2, 1, 0, 0);
    cyc(I_PLAY, 2, 0, 1, 0);
    cyc(I_NONE, 2, 0, 1, 0);
    cyc(I_NEXT, 3, 0, 1, 1);
    cyc(I_NONE, 3, 0, 1, 0);
    cyc(I_PREV, 2, 0, 1, 1);
    cyc(I_NONE, 2, 0, 1, 0);
    cyc(I_DONE, 2, 0, 1, 0);
    cyc(I_NONE, 2, 0, 1, 0);
    // reset from PAUSE with play held across release
    cyc(I_RST | I_PLAY, 0, 0, 0, 0);
    cyc(I_RST | I_PLAY, 0, 0, 0, 0);
    cyc(I_PLAY,         0, 0, 0, 0);
    cyc(I_PLAY,         0, 0, 0, 0);
    cyc(I_NONE,         0, 0, 0, 0);
    cyc(I_PLAY,         0, 1, 0, 1);
    cyc(I_NONE,         0, 1, 0, 0);
    // stop from PLAY
    cyc(I_STOP, 0, 0, 0, 1);
    cyc(I_NONE, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
